// File: rtl/control_pipeline.sv
// Execute/memory/writeback control-word pipeline with PC-redirect resolution
// and a retired-instruction counter.
module control_pipeline #(
    parameter int ALUCTRL_W = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ValidD,
    input  logic                 RegWriteD,
    input  logic [1:0]           ResultSrcD,
    input  logic                 MemWriteD,
    input  logic                 ALUSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic                 BranchD,
    input  logic                 JumpD,
    input  logic                 JalrD,
    input  logic                 FlushE,
    input  logic                 TakenE,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 PCSrcE,
    output logic                 JalrSelE,
    output logic [1:0]           ResultSrcE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic [1:0]           ResultSrcM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic                 ValidW,
    output logic [CNT_W-1:0]     RetireCount
);

    logic                 r_validE;
    logic                 r_regWriteE;
    logic [1:0]           r_resultSrcE;
    logic                 r_memWriteE;
    logic                 r_aluSrcE;
    logic [ALUCTRL_W-1:0] r_aluControlE;
    logic                 r_branchE;
    logic                 r_jumpE;
    logic                 r_jalrE;

    logic                 r_validM;
    logic                 r_regWriteM;
    logic                 r_memWriteM;
    logic [1:0]           r_resultSrcM;

    logic                 r_validW;
    logic                 r_regWriteW;
    logic [1:0]           r_resultSrcW;

    logic [CNT_W-1:0]     r_retireCount;

    logic                 w_pcSrcE;
    logic                 w_jalrSelE;

    // Side-effecting enables are masked by ValidD so an empty slot can never
    // write or redirect; the datapath selects pass through unmasked.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            r_validE      <= 1'b0;
            r_regWriteE   <= 1'b0;
            r_resultSrcE  <= 2'b00;
            r_memWriteE   <= 1'b0;
            r_aluSrcE     <= 1'b0;
            r_aluControlE <= '0;
            r_branchE     <= 1'b0;
            r_jumpE       <= 1'b0;
            r_jalrE       <= 1'b0;
        end else begin
            r_validE      <= ValidD;
            r_regWriteE   <= RegWriteD & ValidD;
            r_resultSrcE  <= ResultSrcD;
            r_memWriteE   <= MemWriteD & ValidD;
            r_aluSrcE     <= ALUSrcD;
            r_aluControlE <= ALUControlD;
            r_branchE     <= BranchD & ValidD;
            r_jumpE       <= JumpD & ValidD;
            r_jalrE       <= JalrD & ValidD;
        end
    end

    // M and W advance every cycle; a flush of E leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_validM     <= 1'b0;
            r_regWriteM  <= 1'b0;
            r_memWriteM  <= 1'b0;
            r_resultSrcM <= 2'b00;
            r_validW     <= 1'b0;
            r_regWriteW  <= 1'b0;
            r_resultSrcW <= 2'b00;
        end else begin
            r_validM     <= r_validE;
            r_regWriteM  <= r_regWriteE;
            r_memWriteM  <= r_memWriteE;
            r_resultSrcM <= r_resultSrcE;
            r_validW     <= r_validM;
            r_regWriteW  <= r_regWriteM;
            r_resultSrcW <= r_resultSrcM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retireCount <= '0;
        end else if (r_validW) begin
            r_retireCount <= r_retireCount + CNT_W'(1);
        end
    end

    assign w_pcSrcE   = r_validE & ((r_branchE & TakenE) | r_jumpE | r_jalrE);
    assign w_jalrSelE = r_validE & r_jalrE;

    assign ALUSrcE     = r_aluSrcE;
    assign ALUControlE = r_aluControlE;
    assign PCSrcE      = w_pcSrcE;
    assign JalrSelE    = w_jalrSelE;
    assign ResultSrcE  = r_resultSrcE;
    assign RegWriteM   = r_regWriteM;
    assign MemWriteM   = r_memWriteM;
    assign ResultSrcM  = r_resultSrcM;
    assign RegWriteW   = r_regWriteW;
    assign ResultSrcW  = r_resultSrcW;
    assign ValidW      = r_validW;
    assign RetireCount = r_retireCount;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: a default-width instance plus a 4-bit
// counter instance sharing the same stimulus to exercise counter wrap.
module tb_control_pipeline;

    logic       clk;
    logic       reset;
    logic       validD;
    logic       regWriteD;
    logic [1:0] resultSrcD;
    logic       memWriteD;
    logic       aluSrcD;
    logic [2:0] aluControlD;
    logic       branchD;
    logic       jumpD;
    logic       jalrD;
    logic       flushE;
    logic       takenE;

    logic        aluSrcE;
    logic [2:0]  aluControlE;
    logic        pcSrcE;
    logic        jalrSelE;
    logic [1:0]  resultSrcE;
    logic        regWriteM;
    logic        memWriteM;
    logic [1:0]  resultSrcM;
    logic        regWriteW;
    logic [1:0]  resultSrcW;
    logic        validW;
    logic [31:0] retireCount;

    logic        sAluSrcE;
    logic [2:0]  sAluControlE;
    logic        sPcSrcE;
    logic        sJalrSelE;
    logic [1:0]  sResultSrcE;
    logic        sRegWriteM;
    logic        sMemWriteM;
    logic [1:0]  sResultSrcM;
    logic        sRegWriteW;
    logic [1:0]  sResultSrcW;
    logic        sValidW;
    logic [3:0]  sRetireCount;

    int checks = 0;
    int errors = 0;

    control_pipeline dut (
        .clk(clk), .reset(reset), .ValidD(validD), .RegWriteD(regWriteD),
        .ResultSrcD(resultSrcD), .MemWriteD(memWriteD), .ALUSrcD(aluSrcD),
        .ALUControlD(aluControlD), .BranchD(branchD), .JumpD(jumpD),
        .JalrD(jalrD), .FlushE(flushE), .TakenE(takenE),
        .ALUSrcE(aluSrcE), .ALUControlE(aluControlE), .PCSrcE(pcSrcE),
        .JalrSelE(jalrSelE), .ResultSrcE(resultSrcE), .RegWriteM(regWriteM),
        .MemWriteM(memWriteM), .ResultSrcM(resultSrcM), .RegWriteW(regWriteW),
        .ResultSrcW(resultSrcW), .ValidW(validW), .RetireCount(retireCount)
    );

    control_pipeline #(.ALUCTRL_W(3), .CNT_W(4)) dutSmall (
        .clk(clk), .reset(reset), .ValidD(validD), .RegWriteD(regWriteD),
        .ResultSrcD(resultSrcD), .MemWriteD(memWriteD), .ALUSrcD(aluSrcD),
        .ALUControlD(aluControlD), .BranchD(branchD), .JumpD(jumpD),
        .JalrD(jalrD), .FlushE(flushE), .TakenE(takenE),
        .ALUSrcE(sAluSrcE), .ALUControlE(sAluControlE), .PCSrcE(sPcSrcE),
        .JalrSelE(sJalrSelE), .ResultSrcE(sResultSrcE), .RegWriteM(sRegWriteM),
        .MemWriteM(sMemWriteM), .ResultSrcM(sResultSrcM), .RegWriteW(sRegWriteW),
        .ResultSrcW(sResultSrcW), .ValidW(sValidW), .RetireCount(sRetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic [1:0] rs,
                                 input logic mw, input logic as, input logic [2:0] ac,
                                 input logic br, input logic jp, input logic jr,
                                 input logic fl);
        validD      = v;
        regWriteD   = rw;
        resultSrcD  = rs;
        memWriteD   = mw;
        aluSrcD     = as;
        aluControlD = ac;
        branchD     = br;
        jumpD       = jp;
        jalrD       = jr;
        flushE      = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        takenE = 1'b0;
        applyStimulus(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_pcsrc", 32'(pcSrcE), 32'd0);
        checkOutput("rst_jalrsel", 32'(jalrSelE), 32'd0);
        checkOutput("rst_regwritem", 32'(regWriteM), 32'd0);
        checkOutput("rst_validw", 32'(validW), 32'd0);
        checkOutput("rst_count", retireCount, 32'd0);
        reset = 1'b0;

        // lw traced through E, M, W and the counter
        applyStimulus(1, 1, 2'b01, 0, 1, 3'b000, 0, 0, 0, 0);
        tick();
        checkOutput("lw_alusrce", 32'(aluSrcE), 32'd1);
        checkOutput("lw_resultsrce", 32'(resultSrcE), 32'd1);
        applyStimulus(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        checkOutput("lw_regwritem", 32'(regWriteM), 32'd1);
        checkOutput("lw_resultsrcm", 32'(resultSrcM), 32'd1);
        tick();
        checkOutput("lw_regwritew", 32'(regWriteW), 32'd1);
        checkOutput("lw_validw", 32'(validW), 32'd1);
        checkOutput("lw_count_pre", retireCount, 32'd0);
        tick();
        checkOutput("lw_count", retireCount, 32'd1);

        // sw flushed on entry to E becomes a bubble
        applyStimulus(1, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 1);
        tick();
        checkOutput("flush_alusrce", 32'(aluSrcE), 32'd0);
        applyStimulus(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        checkOutput("flush_memwritem1", 32'(memWriteM), 32'd0);
        tick();
        checkOutput("flush_memwritem2", 32'(memWriteM), 32'd0);
        checkOutput("flush_validw", 32'(validW), 32'd0);
        tick();
        checkOutput("flush_count", retireCount, 32'd1);

        // unflushed sw reaches memory
        applyStimulus(1, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        checkOutput("sw_memwritem", 32'(memWriteM), 32'd1);
        tick();
        checkOutput("sw_regwritew", 32'(regWriteW), 32'd0);
        checkOutput("sw_memwritem_off", 32'(memWriteM), 32'd0);
        tick();
        checkOutput("sw_count", retireCount, 32'd2);

        // beq, jal, jalr back to back
        applyStimulus(1, 0, 2'b00, 0, 0, 3'b001, 1, 0, 0, 0);
        tick();
        checkOutput("beq_nt_pcsrc", 32'(pcSrcE), 32'd0);
        takenE = 1'b1;
        #1;
        checkOutput("beq_t_pcsrc", 32'(pcSrcE), 32'd1);
        checkOutput("beq_t_jalrsel", 32'(jalrSelE), 32'd0);
        applyStimulus(1, 1, 2'b10, 0, 0, 3'b000, 0, 1, 0, 0);
        takenE = 1'b0;
        tick();
        checkOutput("jal_pcsrc", 32'(pcSrcE), 32'd1);
        checkOutput("jal_jalrsel", 32'(jalrSelE), 32'd0);
        applyStimulus(1, 1, 2'b10, 0, 1, 3'b000, 0, 0, 1, 0);
        tick();
        checkOutput("jalr_pcsrc", 32'(pcSrcE), 32'd1);
        checkOutput("jalr_jalrsel", 32'(jalrSelE), 32'd1);
        applyStimulus(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        checkOutput("idle_pcsrc", 32'(pcSrcE), 32'd0);
        tick();
        checkOutput("jalr_resultsrcw", 32'(resultSrcW), 32'd2);
        checkOutput("jalr_regwritew", 32'(regWriteW), 32'd1);
        checkOutput("jalr_count_pre", retireCount, 32'd4);
        tick();
        checkOutput("jalr_count", retireCount, 32'd5);

        // invalid branch slot with TakenE high: no redirect, no writes
        applyStimulus(0, 1, 2'b00, 1, 0, 3'b101, 1, 0, 0, 0);
        takenE = 1'b1;
        tick();
        checkOutput("inv_pcsrc", 32'(pcSrcE), 32'd0);
        checkOutput("inv_aluctrle", 32'(aluControlE), 32'd5);
        applyStimulus(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        takenE = 1'b0;
        tick();
        checkOutput("inv_regwritem", 32'(regWriteM), 32'd0);
        checkOutput("inv_memwritem", 32'(memWriteM), 32'd0);
        tick();
        checkOutput("inv_regwritew", 32'(regWriteW), 32'd0);
        tick();
        checkOutput("inv_count", retireCount, 32'd5);

        // flush does not stop the older instruction already in E
        applyStimulus(1, 1, 2'b01, 0, 1, 3'b000, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 1);
        tick();
        checkOutput("fl_old_regwritem", 32'(regWriteM), 32'd1);
        checkOutput("fl_new_alusrce", 32'(aluSrcE), 32'd0);
        applyStimulus(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        checkOutput("fl_memwritem", 32'(memWriteM), 32'd0);
        tick();
        tick();
        checkOutput("fl_count", retireCount, 32'd6);

        // counter wrap on the 4-bit instance: 17 back-to-back instructions
        reset = 1'b1;
        tick();
        checkOutput("wrap_rst_small", 32'(sRetireCount), 32'd0);
        checkOutput("wrap_rst_big", retireCount, 32'd0);
        reset = 1'b0;
        applyStimulus(1, 1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) tick();
        checkOutput("wrap_14", 32'(sRetireCount), 32'd14);
        applyStimulus(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        checkOutput("wrap_15", 32'(sRetireCount), 32'd15);
        tick();
        checkOutput("wrap_0", 32'(sRetireCount), 32'd0);
        checkOutput("nowrap_16", retireCount, 32'd16);
        tick();
        checkOutput("wrap_1", 32'(sRetireCount), 32'd1);
        checkOutput("nowrap_17", retireCount, 32'd17);

        // reset with three instructions in flight drops them all
        applyStimulus(1, 1, 2'b00, 1, 0, 3'b000, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        checkOutput("mid_validw_pre", 32'(validW), 32'd1);
        reset = 1'b1;
        applyStimulus(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        checkOutput("mid_count", retireCount, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("mid_regwritew", 32'(regWriteW), 32'd0);
            checkOutput("mid_memwritem", 32'(memWriteM), 32'd0);
            checkOutput("mid_regwritem", 32'(regWriteM), 32'd0);
            tick();
        end
        checkOutput("mid_count_after", retireCount, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Carries the decode-stage control word down the pipeline to execute, memory and writeback, and resolves the PC-redirect decision in execute.
- Sits between the decode-stage control decoder (with the ALU decoder) and the datapath, and consumes the decoded fields registered per stage.
- Inserts bubbles on flush, holds no stall state of its own, and counts retired instructions.

Parameters:
- ALUCTRL_W, 3, width of the ALU control field carried to execute.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- ValidD  input  1  decode stage holds a real instruction.
- RegWriteD  input  1  decoded register-write enable.
- ResultSrcD  input  2  decoded result mux select: 00 ALU, 01 memory, 10 PC+4, 11 immediate/upper.
- MemWriteD  input  1  decoded store enable.
- ALUSrcD  input  1  decoded ALU operand-B select.
- ALUControlD  input  ALUCTRL_W  ALU operation.
- BranchD  input  1  conditional branch.
- JumpD  input  1  jal.
- JalrD  input  1  jalr.
- FlushE  input  1  replace the instruction entering execute with a bubble.
- TakenE  input  1  branch condition true (from the execute comparator).
- ALUSrcE  output  1  registered operand-B select.
- ALUControlE  output  ALUCTRL_W  registered ALU operation.
- PCSrcE  output  1  redirect fetch this cycle.
- JalrSelE  output  1  redirect target comes from the ALU (jalr) rather than PC+imm.
- ResultSrcE  output  2  execute-stage copy, used for load-use detection.
- RegWriteM  output  1  memory-stage register-write enable.
- MemWriteM  output  1  data-memory write enable.
- ResultSrcM  output  2  memory-stage result select.
- RegWriteW  output  1  writeback register-file write enable.
- ResultSrcW  output  2  writeback result mux select.
- ValidW  output  1  writeback holds a real instruction.
- RetireCount  output  CNT_W  retired-instruction count.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Three register stages, E, M and W, each holding a valid bit plus its control fields. No combinational path from D inputs to any registered output.
- D->E update each cycle:
  - if reset, E is cleared;
  - else if FlushE, E is loaded with all zeros, valid=0 (bubble);
  - else E loads the D fields, with valid=ValidD.
- When ValidD=0 and there is no flush, E still loads the D fields but all enables are masked. RegWrite, MemWrite, Branch, Jump and Jalr are ANDed with ValidD, so an invalid slot never writes or redirects.
- E->M and M->W advance unconditionally every cycle. Only RegWrite, MemWrite, ResultSrc and valid propagate past E.
- Latency: a D-stage control appears at E outputs 1 cycle later, at M 2 cycles later, at W 3 cycles later.
- Redirect logic is combinational from E state:
  - PCSrcE = validE & ((BranchE & TakenE) | JumpE | JalrE).
  - JalrSelE = validE & JalrE.
- A not-taken branch gives PCSrcE=0.
- TakenE is ignored when BranchE=0.
- Retire counter:
  - on each rising edge, if reset then RetireCount=0;
  - else if ValidW then RetireCount increments by 1, wrapping modulo 2^CNT_W, with no saturation and no overflow flag.
- Reset values: every output is 0 and all valid bits are 0. PCSrcE and JalrSelE are therefore 0 during and after reset until a valid jump/branch reaches E.
- Simultaneous events:
  - reset beats FlushE;
  - FlushE beats ValidD (the D instruction is discarded; the hazard unit re-issues it);
  - FlushE does not affect M/W, which still receive the old E contents.
- Reset mid-operation: all in-flight instructions are dropped in the same edge, with no writes after reset asserts. RegWriteM/W and MemWriteM are 0 in the first cycle after reset.

Test Plan:
- Reset, then lw (RegWriteD=1, ResultSrcD=01, ALUSrcD=1, ValidD=1) for 1 cycle -> ALUSrcE=1 at +1; RegWriteM=1, ResultSrcM=01 at +2; RegWriteW=1, ValidW=1 at +3; RetireCount 0->1 at +4.
- sw issued with FlushE=1 on the same edge -> E is a bubble; MemWriteM stays 0 for all following cycles; RetireCount unchanged.
- beq (BranchD=1) reaches E with TakenE=0 -> PCSrcE=0. Repeat with TakenE=1 -> PCSrcE=1, JalrSelE=0.
- jal -> PCSrcE=1 in E. jalr -> PCSrcE=1, JalrSelE=1; at W, ResultSrcW=10 and RegWriteW=1.
- Branch with ValidD=0 and TakenE=1 -> PCSrcE=0 and no register writes downstream.
- CNT_W=4, 17 back-to-back valid instructions -> RetireCount reaches 15, wraps to 0, then 1. Assert reset with 3 instructions in flight -> no RegWriteW or MemWriteM pulses follow, and RetireCount=0.
